imem_read_arbiter: RTL and testbench

- Sequences and shares the single combinational instMem read port between two requesters: the CPU fetch path (primary) and a debug/readback port used by benches and program-load checks.
- Registers the memory address, captures the returned instruction one cycle later, and returns it to the winning requester with a one-cycle ack pulse.
- Sits between pc/fetch logic and instMem. Fetch has priority, and a starvation limit guarantees debug progress.

---
 rtl/imem_read_arbiter_if.sv | 30 +++
 rtl/imem_read_arbiter.sv | 148 ++++++++++++++
 tb/tb_imem_read_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_read_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the imem read arbiter and instMem.
// The arbiter uses the slave modport; requesters and memory models use master.
interface imem_read_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  fetch_ack;
   logic [DATA_WIDTH-1:0] fetch_data;
   logic                  fetch_err;
   logic                  dbg_req;
   logic [ADDR_WIDTH-1:0] dbg_addr;
   logic                  dbg_ack;
   logic [DATA_WIDTH-1:0] dbg_data;
   logic                  dbg_err;
   logic [ADDR_WIDTH-1:0] read_address;
   logic [DATA_WIDTH-1:0] instruction;
   logic                  busy;

   modport slave (
      input  fetch_req, fetch_addr, dbg_req, dbg_addr, instruction,
      output fetch_ack, fetch_data, fetch_err, dbg_ack, dbg_data, dbg_err, read_address, busy
   );

   modport master (
      output fetch_req, fetch_addr, dbg_req, dbg_addr, instruction,
      input  fetch_ack, fetch_data, fetch_err, dbg_ack, dbg_data, dbg_err, read_address, busy
   );
endinterface

// File: rtl/imem_read_arbiter.sv
// Shares the combinational instMem read port between fetch (priority) and debug, with a
// starvation limit for debug. Optional IMEM_ARB_MISALIGN_CHECK_EN flags misaligned accesses.
module imem_read_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                clk,
   input logic                reset,
   imem_read_arbiter_if.slave bus
);

   typedef enum logic [0:0] {StIdle, StRead} state_e;

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;  // 1: debug owns the access
   logic [3:0]            starve_cnt_q, starve_cnt_d;
   logic [ADDR_WIDTH-1:0] read_address_q, read_address_d;
   logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
   logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
   logic                  fetch_ack_q, fetch_ack_d;
   logic                  dbg_ack_q, dbg_ack_d;

   logic                  grant_dbg;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_misalign;
   logic [DATA_WIDTH-1:0] rdata;

   assign grant_dbg    = bus.dbg_req & (~bus.fetch_req | (starve_cnt_q == StarveMax));
   assign sel_addr     = grant_dbg ? bus.dbg_addr : bus.fetch_addr;
   assign sel_misalign = |sel_addr[1:0];

`ifdef IMEM_ARB_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   logic fetch_err_q, fetch_err_d;
   logic dbg_err_q, dbg_err_d;

   assign rdata = misalign_q ? '0 : bus.instruction;
`else
   logic unused_misalign;

   assign unused_misalign = sel_misalign;
   assign rdata           = bus.instruction;
`endif

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      starve_cnt_d   = starve_cnt_q;
      read_address_d = read_address_q;
      fetch_data_d   = fetch_data_q;
      dbg_data_d     = dbg_data_q;
      fetch_ack_d    = 1'b0;
      dbg_ack_d      = 1'b0;
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
      misalign_d     = misalign_q;
      fetch_err_d    = fetch_err_q;
      dbg_err_d      = dbg_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.fetch_req || bus.dbg_req) begin
               state_d        = StRead;
               owner_d        = grant_dbg;
               read_address_d = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
               misalign_d     = sel_misalign;
`endif
            end
            // Count only fetch grants that actually made a waiting debug request wait.
            if (!bus.dbg_req || grant_dbg) begin
               starve_cnt_d = 4'd0;
            end else if (bus.fetch_req) begin
               starve_cnt_d = (starve_cnt_q == StarveMax) ? StarveMax : starve_cnt_q + 4'd1;
            end
         end
         StRead: begin
            state_d = StIdle;
            if (owner_q) begin
               dbg_data_d = rdata;
               dbg_ack_d  = 1'b1;
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
               dbg_err_d  = misalign_q;
`endif
            end else begin
               fetch_data_d = rdata;
               fetch_ack_d  = 1'b1;
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
               fetch_err_d  = misalign_q;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         owner_q        <= 1'b0;
         starve_cnt_q   <= 4'd0;
         read_address_q <= '0;
         fetch_data_q   <= '0;
         dbg_data_q     <= '0;
         fetch_ack_q    <= 1'b0;
         dbg_ack_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         starve_cnt_q   <= starve_cnt_d;
         read_address_q <= read_address_d;
         fetch_data_q   <= fetch_data_d;
         dbg_data_q     <= dbg_data_d;
         fetch_ack_q    <= fetch_ack_d;
         dbg_ack_q      <= dbg_ack_d;
      end
   end

`ifdef IMEM_ARB_MISALIGN_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_q  <= 1'b0;
         fetch_err_q <= 1'b0;
         dbg_err_q   <= 1'b0;
      end else begin
         misalign_q  <= misalign_d;
         fetch_err_q <= fetch_err_d;
         dbg_err_q   <= dbg_err_d;
      end
   end

   assign bus.fetch_err = fetch_err_q;
   assign bus.dbg_err   = dbg_err_q;
`else
   assign bus.fetch_err = 1'b0;
   assign bus.dbg_err   = 1'b0;
`endif

   assign bus.read_address = read_address_q;
   assign bus.fetch_data   = fetch_data_q;
   assign bus.dbg_data     = dbg_data_q;
   assign bus.fetch_ack    = fetch_ack_q;
   assign bus.dbg_ack      = dbg_ack_q;
   assign bus.busy         = (state_q == StRead);

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Directed bench for imem_read_arbiter: reset, single reads, starvation rotation,
// misalign handling, mid-read reset and back-to-back fetches.
module tb_imem_read_arbiter;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   imem_read_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   imem_read_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .STARVE_LIMIT(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Small instMem model indexed by word address.
   always_comb begin
      case (bus.read_address[4:2])
         3'd0:    bus.instruction = 32'h381d3ffc;
         3'd1:    bus.instruction = 32'h38080004;
         3'd2:    bus.instruction = 32'h38090001;
         default: bus.instruction = 32'h00000013;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [103:0] outs;
      reset = 1'b1;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.dbg_req    = 1'b0;
      bus.dbg_addr   = '0;
      step();
      outs = {bus.fetch_ack, bus.dbg_ack, bus.fetch_err, bus.dbg_err, bus.busy,
              bus.read_address, bus.fetch_data, bus.dbg_data[2:0]};
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", outs);
      end
      total++;
      if (bus.dbg_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_dbg_data got=%h want=0", bus.dbg_data);
      end
      #3 reset = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0;
      step();
      total++;
      if (bus.read_address !== 32'h0 || bus.busy !== 1'b1 || bus.fetch_ack !== 1'b0) begin
         bad++;
         $display("FAIL fetch_grant ra=%h busy=%b ack=%b want ra=0 busy=1 ack=0",
                  bus.read_address, bus.busy, bus.fetch_ack);
      end
      step();
      total++;
      if (bus.fetch_ack !== 1'b1 || bus.fetch_data !== 32'h381d3ffc || bus.dbg_ack !== 1'b0) begin
         bad++;
         $display("FAIL fetch_ack ack=%b data=%h dack=%b want ack=1 data=381d3ffc dack=0",
                  bus.fetch_ack, bus.fetch_data, bus.dbg_ack);
      end
      bus.fetch_req = 1'b0;
      step();
      total++;
      if (bus.fetch_ack !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL fetch_pulse ack=%b busy=%b want 0 0", bus.fetch_ack, bus.busy);
      end
   endtask

   task automatic test_dbg();
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 32'h8;
      step();
      total++;
      if (bus.read_address !== 32'h8 || bus.dbg_ack !== 1'b0) begin
         bad++;
         $display("FAIL dbg_grant ra=%h ack=%b want ra=8 ack=0", bus.read_address, bus.dbg_ack);
      end
      step();
      total++;
      if (bus.dbg_ack !== 1'b1 || bus.dbg_data !== 32'h38090001 || bus.fetch_ack !== 1'b0) begin
         bad++;
         $display("FAIL dbg_ack ack=%b data=%h fack=%b want ack=1 data=38090001 fack=0",
                  bus.dbg_ack, bus.dbg_data, bus.fetch_ack);
      end
      total++;
      if (bus.fetch_data !== 32'h381d3ffc) begin
         bad++;
         $display("FAIL dbg_fetch_hold got=%h want=381d3ffc", bus.fetch_data);
      end
      bus.dbg_req = 1'b0;
      step();
      total++;
      if (bus.dbg_ack !== 1'b0) begin
         bad++;
         $display("FAIL dbg_pulse got=%b want=0", bus.dbg_ack);
      end
   endtask

   task automatic test_starve();
      logic exp_owner [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int   n_ack;
      bit   overlap;
      n_ack   = 0;
      overlap = 1'b0;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h4;
      bus.dbg_req    = 1'b1;
      bus.dbg_addr   = 32'h8;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.fetch_ack && bus.dbg_ack) overlap = 1'b1;
         if ((bus.fetch_ack || bus.dbg_ack) && n_ack < 10) begin
            total++;
            if (bus.dbg_ack !== exp_owner[n_ack]) begin
               bad++;
               $display("FAIL starve_owner ack%0d dbg=%b want dbg=%b", n_ack, bus.dbg_ack,
                        exp_owner[n_ack]);
            end
            total++;
            if (bus.fetch_ack && bus.fetch_data !== 32'h38080004) begin
               bad++;
               $display("FAIL starve_fdata ack%0d got=%h want=38080004", n_ack, bus.fetch_data);
            end else if (bus.dbg_ack && bus.dbg_data !== 32'h38090001) begin
               bad++;
               $display("FAIL starve_ddata ack%0d got=%h want=38090001", n_ack, bus.dbg_data);
            end
            n_ack++;
         end
      end
      total++;
      if (n_ack != 10 || overlap) begin
         bad++;
         $display("FAIL starve_count acks=%0d overlap=%b want 10 0", n_ack, overlap);
      end
      bus.fetch_req = 1'b0;
      bus.dbg_req   = 1'b0;
      step();
   endtask

   task automatic test_misalign();
      logic [31:0] exp_data;
      logic        exp_err;
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
      exp_data = 32'h0;
      exp_err  = 1'b1;
`else
      exp_data = 32'h38080004;
      exp_err  = 1'b0;
`endif
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h6;
      step();
      total++;
      if (bus.read_address !== 32'h4) begin
         bad++;
         $display("FAIL misalign_addr got=%h want=4", bus.read_address);
      end
      step();
      total++;
      if (bus.fetch_ack !== 1'b1 || bus.fetch_data !== exp_data || bus.fetch_err !== exp_err) begin
         bad++;
         $display("FAIL misalign_ack ack=%b data=%h err=%b want ack=1 data=%h err=%b",
                  bus.fetch_ack, bus.fetch_data, bus.fetch_err, exp_data, exp_err);
      end
      bus.fetch_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_read();
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h8;
      step();
      total++;
      if (bus.busy !== 1'b1 || bus.read_address !== 32'h8) begin
         bad++;
         $display("FAIL midrst_grant busy=%b ra=%h want 1 8", bus.busy, bus.read_address);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.read_address !== 32'h0 || bus.fetch_data !== 32'h0 ||
          bus.dbg_data !== 32'h0 || bus.fetch_ack !== 1'b0 || bus.dbg_ack !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async busy=%b ra=%h fd=%h dd=%h fa=%b da=%b want all 0",
                  bus.busy, bus.read_address, bus.fetch_data, bus.dbg_data, bus.fetch_ack,
                  bus.dbg_ack);
      end
      bus.fetch_req = 1'b0;
      step();
      total++;
      if (bus.fetch_ack !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL midrst_noack ack=%b busy=%b want 0 0", bus.fetch_ack, bus.busy);
      end
      #3 reset = 1'b0;
      step();
      test_fetch();
   endtask

   task automatic test_back_to_back();
      logic exp_busy [4] = '{1, 0, 1, 0};
      logic exp_ack  [4] = '{0, 1, 0, 1};
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h4;
      for (int c = 0; c < 4; c++) begin
         step();
         total++;
         if (bus.busy !== exp_busy[c] || bus.fetch_ack !== exp_ack[c]) begin
            bad++;
            $display("FAIL b2b_cycle%0d busy=%b ack=%b want busy=%b ack=%b", c, bus.busy,
                     bus.fetch_ack, exp_busy[c], exp_ack[c]);
         end
      end
      bus.fetch_req = 1'b0;
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_fetch();
      test_dbg();
      test_starve();
      test_misalign();
      test_reset_mid_read();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
